one_shot_trigger: RTL

Four-channel programmable one-shot pulse generator with an Avalon-MM slave. It lives inside `kvb_system` on the 50 MHz system clock and drives the camera trigger pins `cam_trigger[3:0]` of the top level. Each channel fires a single pulse after a programmable delay and of a programmable width. A channel is fired by a register write, or optionally by the rising edge of the 16 kHz sync clock.

---
 rtl/one_shot_trigger_if.sv | 18 +
 rtl/one_shot_trigger.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/one_shot_trigger_if.sv
// Avalon-MM slave bundle for one_shot_trigger: word addressed, fixed read latency of 1, no waitrequest.
interface one_shot_trigger_if;
  logic [3:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/one_shot_trigger.sv
// Programmable one-shot pulse generator: each channel fires one delayed pulse of programmable width.
// Macro ONE_SHOT_SYNC_TRIG_EN builds the sync_trig synchronizer and makes CTRL[11:8] (sync_sel) writable.
module one_shot_trigger #(
  parameter int CNT_W = 24,
  parameter int NCH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  one_shot_trigger_if.slave avs,
  input  logic              sync_trig,
  output logic [NCH-1:0]    trigger
);

  typedef enum logic [1:0] {IDLE, DLY, PULSE} state_t;

  localparam logic [3:0] A_CTRL = 4'h0;
  localparam logic [3:0] A_STAT = 4'h1;

  logic [NCH-1:0]   en_q, pol_q, sel_q, ovr_q, busy_q;
  logic [NCH-1:0]   en_nxt, fire_req, ovr_nxt;
  logic [CNT_W-1:0] dly_q [NCH];
  logic [CNT_W-1:0] wid_q [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_nxt [NCH];
  logic [CNT_W-1:0] wsh_q [NCH];
  logic [CNT_W-1:0] wsh_nxt [NCH];
  state_t           st_q [NCH];
  state_t           st_nxt [NCH];
  logic             ctrl_wr, fire_wr, sync_rise;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  assign ctrl_wr      = avs.avs_write && (avs.avs_address == A_CTRL);
  assign fire_wr      = avs.avs_write && (avs.avs_address == A_STAT);
  assign unused_wdata = ^avs.avs_writedata[31:CNT_W];

  // The FSMs see the enable being written this cycle, so a disable acts on the write edge itself.
  assign en_nxt   = ctrl_wr ? avs.avs_writedata[NCH-1:0] : en_q;
  assign fire_req = (fire_wr ? avs.avs_writedata[NCH-1:0] : '0) | (sync_rise ? sel_q : '0);

`ifdef ONE_SHOT_SYNC_TRIG_EN
  logic [2:0] sync_ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
      sel_q   <= '0;
    end else begin
      sync_ff <= {sync_ff[1:0], sync_trig};
      if (ctrl_wr) sel_q <= avs.avs_writedata[8 +: NCH];
    end
  end

  assign sync_rise = sync_ff[1] & ~sync_ff[2];
`else
  logic unused_sync;
  assign unused_sync = sync_trig;
  assign sel_q       = '0;
  assign sync_rise   = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      st_nxt[i]  = st_q[i];
      cnt_nxt[i] = cnt_q[i];
      wsh_nxt[i] = wsh_q[i];
      ovr_nxt[i] = ovr_q[i];
      if (fire_wr && avs.avs_writedata[4+i]) ovr_nxt[i] = 1'b0;
      if (!en_nxt[i]) begin
        st_nxt[i] = IDLE;
      end else begin
        case (st_q[i])
          IDLE: begin
            if (fire_req[i]) begin
              wsh_nxt[i] = wid_q[i];
              if (dly_q[i] == '0) begin
                st_nxt[i]  = PULSE;
                cnt_nxt[i] = at_least_one(wid_q[i]);
              end else begin
                st_nxt[i]  = DLY;
                cnt_nxt[i] = dly_q[i];
              end
            end
          end
          DLY: begin
            if (cnt_q[i] <= CNT_W'(1)) begin
              st_nxt[i]  = PULSE;
              cnt_nxt[i] = at_least_one(wsh_q[i]);
            end else begin
              cnt_nxt[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          PULSE: begin
            if (cnt_q[i] <= CNT_W'(1)) st_nxt[i] = IDLE;
            else                       cnt_nxt[i] = cnt_q[i] - CNT_W'(1);
          end
          default: st_nxt[i] = IDLE;
        endcase
      end
      // Setting beats clearing when both land on the same edge.
      if (fire_req[i] && en_nxt[i] && st_q[i] != IDLE) ovr_nxt[i] = 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (avs.avs_address == A_CTRL)      rd_mux = 32'({sel_q, pol_q, en_q});
    else if (avs.avs_address == A_STAT) rd_mux = 32'({ovr_q, busy_q});
    for (int i = 0; i < NCH; i++) begin
      if (avs.avs_address == 4'(2 + 2*i)) rd_mux = 32'(dly_q[i]);
      if (avs.avs_address == 4'(3 + 2*i)) rd_mux = 32'(wid_q[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q             <= '0;
      pol_q            <= '0;
      ovr_q            <= '0;
      busy_q           <= '0;
      trigger          <= '0;
      avs.avs_readdata <= '0;
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
        wsh_q[i] <= '0;
        dly_q[i] <= '0;
        wid_q[i] <= '0;
      end
    end else begin
      en_q             <= en_nxt;
      ovr_q            <= ovr_nxt;
      avs.avs_readdata <= avs.avs_read ? rd_mux : '0;
      if (ctrl_wr) pol_q <= avs.avs_writedata[4 +: NCH];
      for (int i = 0; i < NCH; i++) begin
        st_q[i]    <= st_nxt[i];
        cnt_q[i]   <= cnt_nxt[i];
        wsh_q[i]   <= wsh_nxt[i];
        busy_q[i]  <= (st_q[i] != IDLE);
        trigger[i] <= (st_q[i] == PULSE) ^ pol_q[i];
        if (avs.avs_write && avs.avs_address == 4'(2 + 2*i)) dly_q[i] <= avs.avs_writedata[CNT_W-1:0];
        if (avs.avs_write && avs.avs_address == 4'(3 + 2*i)) wid_q[i] <= avs.avs_writedata[CNT_W-1:0];
      end
    end
  end

endmodule
